// File: rtl/mil_std_csr_bank_if.sv
// rtl/mil_std_csr_bank_if.sv - Avalon-MM-style register bus between the HPS bridge and the CSR bank
interface mil_std_csr_bank_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/mil_std_csr_bank.sv
// rtl/mil_std_csr_bank.sv - multi-channel MIL-STD-1553 CSR bank with receive FIFOs and combined interrupt
module mil_std_csr_bank #(
    parameter int CH_CNT        = 2,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    mil_std_csr_bank_if.slave      avs,
    output logic                   irq_o,
    output logic [CH_CNT-1:0]      rcv_enable_o,
    input  logic [CH_CNT-1:0]      rcv_busy_i,
    input  logic [CH_CNT-1:0]      rcv_valid_i,
    input  logic [16*CH_CNT-1:0]   rcv_data_i,
    input  logic [CH_CNT-1:0]      rcv_sync_c_i,
    input  logic [CH_CNT-1:0]      rcv_parity_err_i,
    output logic [CH_CNT-1:0]      xmt_enable_o,
    input  logic [CH_CNT-1:0]      xmt_busy_i,
    input  logic [CH_CNT-1:0]      xmt_done_i,
    output logic [CH_CNT-1:0]      xmt_send_o,
    output logic [16*CH_CNT-1:0]   xmt_data_o,
    output logic [CH_CNT-1:0]      xmt_sync_c_o
);
    localparam int AW  = $clog2(CH_CNT) + 4;
    localparam int CHW = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
    localparam int PW  = $clog2(RX_FIFO_DEPTH);
    localparam int LW  = PW + 1;

    // Per-channel register state
    logic [CH_CNT-1:0]            rcv_en;
    logic [CH_CNT-1:0][15:0]      rcv_ie;
    logic [CH_CNT-1:0][1:0]       rcv_vec;
    logic [CH_CNT-1:0]            xmt_en;
    logic [CH_CNT-1:0][15:0]      xmt_ie;
    logic [CH_CNT-1:0]            xmt_vec;
    logic [CH_CNT-1:0][15:0]      xmt_word;
    logic [CH_CNT-1:0]            xmt_sync;

    // Receive FIFOs: entry is {parity, sync_c, data}
    logic [17:0]                  fifo_mem [CH_CNT][RX_FIFO_DEPTH];
    logic [CH_CNT-1:0][PW-1:0]    rd_ptr;
    logic [CH_CNT-1:0][PW-1:0]    wr_ptr;
    logic [CH_CNT-1:0][LW-1:0]    level;

    logic [CHW-1:0]  ch;
    logic            ch_ok;
    logic [3:0]      idx;
    logic            rd_req;
    logic [15:0]     rd_mux;
    logic [17:0]     head;
    logic            head_ok;
    logic [CH_CNT-1:0] wsel, pop, push_ok, ovf, flush, send_ok;
    logic            irq_any;

    assign idx    = avs.address[3:0];
    // A simultaneous write wins; the read is dropped entirely.
    assign rd_req = avs.read && !avs.write;

    generate
        if (CH_CNT > 1) begin : g_multi
            assign ch = avs.address[AW-1:4];
        end else begin : g_single
            assign ch = '0;
        end
        if (CH_CNT == (1 << CHW)) begin : g_full_range
            assign ch_ok = 1'b1;
        end else begin : g_part_range
            assign ch_ok = (ch < CHW'(CH_CNT));
        end
    endgenerate

    assign rcv_enable_o = rcv_en;
    assign xmt_enable_o = xmt_en;
    assign xmt_data_o   = xmt_word;
    assign xmt_sync_c_o = xmt_sync;

    // Per-channel strobes: bus decode, FIFO push/pop/flush, send qualification, interrupt cause
    always_comb begin
        wsel    = '0;
        pop     = '0;
        push_ok = '0;
        ovf     = '0;
        flush   = '0;
        send_ok = '0;
        irq_any = 1'b0;
        for (int c = 0; c < CH_CNT; c++) begin
            logic hit;
            logic push_req;
            logic full;
            hit        = ch_ok && (ch == CHW'(c));
            wsel[c]    = avs.write && hit;
            pop[c]     = rd_req && hit && (idx == 4'd3) && (level[c] != '0);
            flush[c]   = wsel[c] && (idx == 4'd0) && !avs.writedata[0];
            push_req   = rcv_valid_i[c] && rcv_en[c] && !flush[c];
            full       = (level[c] == LW'(RX_FIFO_DEPTH));
            push_ok[c] = push_req && (!full || pop[c]);
            ovf[c]     = push_req && full && !pop[c];
            send_ok[c] = wsel[c] && (idx == 4'd9) && avs.writedata[0]
                         && xmt_en[c] && !xmt_busy_i[c];
            irq_any    = irq_any | (|(rcv_vec[c] & rcv_ie[c][1:0]))
                                 | (xmt_vec[c] & xmt_ie[c][0]);
        end
    end

    // Read mux for the addressed channel; an empty FIFO reads as all zero
    always_comb begin
        rd_mux  = '0;
        head    = fifo_mem[ch][rd_ptr[ch]];
        head_ok = (level[ch] != '0);
        if (ch_ok) begin
            case (idx)
                4'd0:    rd_mux = {rcv_busy_i[ch], 14'b0, rcv_en[ch]};
                4'd1:    rd_mux = rcv_ie[ch];
                4'd2:    rd_mux = {14'b0, rcv_vec[ch]};
                4'd3:    rd_mux = head_ok ? head[15:0] : 16'h0000;
                4'd4:    rd_mux = {{(8-LW){1'b0}}, level[ch], 7'b0, head_ok & head[16]};
                4'd5:    rd_mux = {15'b0, head_ok & head[17]};
                4'd6:    rd_mux = {xmt_busy_i[ch], 14'b0, xmt_en[ch]};
                4'd7:    rd_mux = xmt_ie[ch];
                4'd8:    rd_mux = {15'b0, xmt_vec[ch]};
                4'd10:   rd_mux = xmt_word[ch];
                4'd11:   rd_mux = {xmt_sync[ch], 15'b0};
                default: rd_mux = '0;
            endcase
        end
    end

    // FIFO storage needs no reset: the level counters gate every read of it
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < CH_CNT; c++) begin
            if (push_ok[c]) begin
                fifo_mem[c][wr_ptr[c]] <= {rcv_parity_err_i[c], rcv_sync_c_i[c], rcv_data_i[16*c +: 16]};
            end
        end
    end

    // Register file, FIFO pointers, vectors, send pulse, read response and interrupt
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rcv_en            <= '0;
            rcv_ie            <= '0;
            rcv_vec           <= '0;
            xmt_en            <= '0;
            xmt_ie            <= '0;
            xmt_vec           <= '0;
            xmt_word          <= '0;
            xmt_sync          <= '0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            level             <= '0;
            xmt_send_o        <= '0;
            irq_o             <= 1'b0;
            avs.readdata      <= '0;
            avs.readdatavalid <= 1'b0;
        end else begin
            avs.readdatavalid <= rd_req;
            if (rd_req) begin
                avs.readdata <= rd_mux;
            end
            irq_o      <= irq_any;
            xmt_send_o <= send_ok;
            for (int c = 0; c < CH_CNT; c++) begin
                if (wsel[c]) begin
                    case (idx)
                        4'd0:    rcv_en[c]   <= avs.writedata[0];
                        4'd1:    rcv_ie[c]   <= avs.writedata;
                        4'd6:    xmt_en[c]   <= avs.writedata[0];
                        4'd7:    xmt_ie[c]   <= avs.writedata;
                        4'd10:   xmt_word[c] <= avs.writedata;
                        4'd11:   xmt_sync[c] <= avs.writedata[15];
                        default: ;
                    endcase
                end
                // Set events are OR-ed after the W1C mask so a same-cycle set wins
                rcv_vec[c] <= (rcv_vec[c] & ~((wsel[c] && idx == 4'd2) ? avs.writedata[1:0] : 2'b00))
                              | {ovf[c], push_ok[c]};
                xmt_vec[c] <= (xmt_vec[c] & ~(wsel[c] && idx == 4'd8 && avs.writedata[0]))
                              | xmt_done_i[c];
                if (flush[c]) begin
                    rd_ptr[c] <= wr_ptr[c];
                    level[c]  <= '0;
                end else begin
                    if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (pop[c])     rd_ptr[c] <= rd_ptr[c] + 1'b1;
                    level[c] <= level[c] + LW'(push_ok[c]) - LW'(pop[c]);
                end
            end
        end
    end
endmodule

// File: tb/tb_mil_std_csr_bank.sv
// tb/tb_mil_std_csr_bank.sv - directed self-checking bench for mil_std_csr_bank
module tb_mil_std_csr_bank;
    localparam int CH_CNT = 2;
    localparam int AW     = 5;

    logic               clk_i = 1'b0;
    logic               rst_n_i;
    logic               irq_o;
    logic [1:0]         rcv_enable_o;
    logic [1:0]         rcv_busy_i;
    logic [1:0]         rcv_valid_i;
    logic [31:0]        rcv_data_i;
    logic [1:0]         rcv_sync_c_i;
    logic [1:0]         rcv_parity_err_i;
    logic [1:0]         xmt_enable_o;
    logic [1:0]         xmt_busy_i;
    logic [1:0]         xmt_done_i;
    logic [1:0]         xmt_send_o;
    logic [31:0]        xmt_data_o;
    logic [1:0]         xmt_sync_c_o;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] d;

    mil_std_csr_bank_if #(.ADDR_W(AW)) avs ();

    mil_std_csr_bank #(.CH_CNT(CH_CNT), .RX_FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .avs(avs.slave), .irq_o(irq_o),
        .rcv_enable_o(rcv_enable_o), .rcv_busy_i(rcv_busy_i), .rcv_valid_i(rcv_valid_i),
        .rcv_data_i(rcv_data_i), .rcv_sync_c_i(rcv_sync_c_i), .rcv_parity_err_i(rcv_parity_err_i),
        .xmt_enable_o(xmt_enable_o), .xmt_busy_i(xmt_busy_i), .xmt_done_i(xmt_done_i),
        .xmt_send_o(xmt_send_o), .xmt_data_o(xmt_data_o), .xmt_sync_c_o(xmt_sync_c_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input int ch, input int idx, input logic [15:0] data);
        @(posedge clk_i); #1;
        avs.address = AW'(ch * 16 + idx); avs.writedata = data; avs.write = 1'b1;
        @(posedge clk_i); #1;
        avs.write = 1'b0;
    endtask

    task automatic rd(input int ch, input int idx, output logic [15:0] data);
        @(posedge clk_i); #1;
        avs.address = AW'(ch * 16 + idx); avs.read = 1'b1;
        @(posedge clk_i); #1;
        avs.read = 1'b0;
        @(negedge clk_i);
        chk("rdvalid_high", 32'(avs.readdatavalid), 32'd1);
        data = avs.readdata;
        @(negedge clk_i);
        chk("rdvalid_low", 32'(avs.readdatavalid), 32'd0);
    endtask

    task automatic push(input int ch, input logic [15:0] data, input logic sync, input logic par);
        @(posedge clk_i); #1;
        rcv_valid_i[ch] = 1'b1; rcv_data_i[16*ch +: 16] = data;
        rcv_sync_c_i[ch] = sync; rcv_parity_err_i[ch] = par;
        @(posedge clk_i); #1;
        rcv_valid_i = '0; rcv_sync_c_i = '0; rcv_parity_err_i = '0;
    endtask

    initial begin
        rst_n_i = 1'b0;
        avs.address = '0; avs.read = 1'b0; avs.write = 1'b0; avs.writedata = '0;
        rcv_busy_i = '0; rcv_valid_i = '0; rcv_data_i = '0; rcv_sync_c_i = '0;
        rcv_parity_err_i = '0; xmt_busy_i = '0; xmt_done_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_valid", 32'(avs.readdatavalid), 32'd0);
        chk("rst_send", 32'(xmt_send_o), 32'd0);
        chk("rst_enables", {28'd0, rcv_enable_o, xmt_enable_o}, 32'd0);
        rst_n_i = 1'b1;

        // Every index of both channels reads zero after reset
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                rd(c, i, d);
                chk($sformatf("rst_read_ch%0d_idx%0d", c, i), 32'(d), 32'd0);
            end
        end
        chk("rst_irq_after_reads", 32'(irq_o), 32'd0);

        // Channel 1 FIFO ordering and head status
        wr(1, 0, 16'h0001);
        chk("ch1_enable_out", 32'(rcv_enable_o), 32'h2);
        push(1, 16'hA5A5, 1'b1, 1'b0);
        push(1, 16'h1234, 1'b0, 1'b1);
        rd(1, 4, d); chk("ch1_status", 32'(d), 32'h0201);
        rd(1, 3, d); chk("ch1_word0", 32'(d), 32'hA5A5);
        rd(1, 5, d); chk("ch1_errors", 32'(d), 32'h0001);
        rd(1, 3, d); chk("ch1_word1", 32'(d), 32'h1234);
        rd(1, 3, d); chk("ch1_empty_word", 32'(d), 32'h0000);
        rd(1, 4, d); chk("ch1_empty_status", 32'(d), 32'h0000);

        // Channel 0 overflow, then W1C of the overflow bit
        wr(0, 0, 16'h0001);
        for (int k = 1; k <= 5; k++) push(0, 16'(16'h1000 + k), 1'b0, 1'b0);
        rd(0, 4, d); chk("ovf_level", 32'(d), 32'h0400);
        rd(0, 2, d); chk("ovf_vector", 32'(d), 32'h0003);
        wr(0, 2, 16'h0002);
        rd(0, 2, d); chk("ovf_w1c", 32'(d), 32'h0001);

        // Push into a full FIFO while popping in the same cycle
        wr(0, 2, 16'h0003);
        @(posedge clk_i); #1;
        avs.address = AW'(3); avs.read = 1'b1;
        rcv_valid_i[0] = 1'b1; rcv_data_i[15:0] = 16'h7777;
        @(posedge clk_i); #1;
        avs.read = 1'b0; rcv_valid_i = '0;
        @(negedge clk_i);
        chk("fullpop_data", 32'(avs.readdata), 32'h1001);
        rd(0, 4, d); chk("fullpop_level", 32'(d), 32'h0400);
        rd(0, 2, d); chk("fullpop_vector", 32'(d), 32'h0001);

        // Disabling the receiver flushes the FIFO but keeps the vector
        wr(0, 0, 16'h0000);
        rd(0, 4, d); chk("flush_level", 32'(d), 32'h0000);
        rd(0, 2, d); chk("flush_vector_kept", 32'(d), 32'h0001);
        wr(0, 2, 16'h0001);

        // Interrupt timing on channel 0
        wr(0, 1, 16'h0001);
        wr(0, 0, 16'h0001);
        @(negedge clk_i); chk("irq_idle", 32'(irq_o), 32'd0);
        push(0, 16'hCAFE, 1'b0, 1'b0);
        @(negedge clk_i); chk("irq_same_cycle", 32'(irq_o), 32'd0);
        @(negedge clk_i); chk("irq_asserted", 32'(irq_o), 32'd1);
        wr(0, 2, 16'h0001);
        @(negedge clk_i); chk("irq_hold_after_w1c", 32'(irq_o), 32'd1);
        @(negedge clk_i); chk("irq_cleared", 32'(irq_o), 32'd0);

        // Transmit send strobe
        wr(0, 10, 16'hBEEF);
        wr(0, 6, 16'h0001);
        chk("xmt_data", {16'd0, xmt_data_o[15:0]}, 32'hBEEF);
        chk("xmt_enable_out", 32'(xmt_enable_o), 32'h1);
        @(posedge clk_i); #1;
        avs.address = AW'(9); avs.writedata = 16'h0001; avs.write = 1'b1;
        @(negedge clk_i); chk("send_before", 32'(xmt_send_o), 32'd0);
        @(posedge clk_i); #1; avs.write = 1'b0;
        @(negedge clk_i); chk("send_pulse", 32'(xmt_send_o), 32'd1);
        @(negedge clk_i); chk("send_single", 32'(xmt_send_o), 32'd0);

        xmt_busy_i = 2'b01;
        rd(0, 6, d); chk("xmt_ctrl_busy", 32'(d), 32'h8001);
        wr(0, 9, 16'h0001);
        @(negedge clk_i); chk("send_busy_none", 32'(xmt_send_o), 32'd0);
        @(negedge clk_i); chk("send_busy_none2", 32'(xmt_send_o), 32'd0);
        xmt_busy_i = 2'b00;

        // Transmit done vector
        @(posedge clk_i); #1; xmt_done_i = 2'b01;
        @(posedge clk_i); #1; xmt_done_i = 2'b00;
        rd(0, 8, d); chk("xmt_done_vec", 32'(d), 32'h0001);

        // Read and write together: write executes, read dropped
        @(posedge clk_i); #1;
        avs.address = AW'(10); avs.writedata = 16'h1111; avs.write = 1'b1; avs.read = 1'b1;
        @(posedge clk_i); #1; avs.write = 1'b0; avs.read = 1'b0;
        @(negedge clk_i); chk("rdwr_no_valid", 32'(avs.readdatavalid), 32'd0);
        rd(0, 10, d); chk("rdwr_write_done", 32'(d), 32'h1111);

        // Unimplemented index writes are ignored
        wr(0, 12, 16'hFFFF);
        rd(0, 12, d); chk("idx12_zero", 32'(d), 32'h0000);

        // Asynchronous reset kills a pending send pulse
        @(posedge clk_i); #1;
        avs.address = AW'(9); avs.writedata = 16'h0001; avs.write = 1'b1;
        @(posedge clk_i); #1; avs.write = 1'b0;
        chk("send_pre_reset", 32'(xmt_send_o), 32'd1);
        #1 rst_n_i = 1'b0;
        #1 chk("send_async_reset", 32'(xmt_send_o), 32'd0);
        chk("enable_async_reset", 32'(xmt_enable_o), 32'd0);
        @(posedge clk_i); #1 rst_n_i = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
